imem_responder: RTL and testbench
=================================

// Module: imem_responder
// PURPOSE
//  Memory-side responder for the I-cache miss interface (m_a/m_strobe -> m_dout/m_ready).
//  Latches one word-read request, reads an internal word ROM, returns data after a fixed
//  latency with a one-cycle m_ready pulse. Sits between the I-cache and instruction storage.
//  It also serves as the bench/FPGA memory model for cache bring-up.
// PARAMETERS
//  A_WIDTH    32          address width, byte address, word aligned (bits [1:0] ignored)
//  IDX_W      10          ROM index width; depth = 1<<IDX_W words
//  LATENCY    4           cycles from accepting edge to m_ready cycle; legal range 1..15
//  BASE_ADDR  32'h0       region base; only upper bits [A_WIDTH-1:IDX_W+2] are used
//  INIT_FILE  "imem.hex"  $readmemh image for the ROM; "" leaves the ROM uninitialised
// PORTS
//  clk        in   1        clock
//  clrn       in   1        reset, asynchronous, active-low
//  m_a        in   A_WIDTH  request address; sampled only on the accepting edge
//  m_strobe   in   1        read request; level, held by the cache while it misses
//  m_dout     out  32       read data; valid in the m_ready cycle, held until the next response
//  m_ready    out  1        one-cycle response pulse
//  m_busy     out  1        high in WAIT and RESP (request in flight)
//  m_err      out  1        range error, qualified by m_ready (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state=IDLE; m_ready=0, m_busy=0, m_dout=0, m_err=0, cnt=0. ROM contents are not reset.
//  All outputs are registered.
//  FSM: IDLE -> WAIT -> RESP -> IDLE.
//   IDLE: if m_strobe at an edge -> accept: latch idx=m_a[IDX_W+1:2]; issue ROM read;
//         cnt<=LATENCY-1; next state is RESP if LATENCY==1, otherwise WAIT.
//   WAIT: decrement cnt each edge; at the edge where cnt==1, go to RESP. m_strobe is ignored.
//   RESP: m_ready=1 for exactly this cycle; m_dout=ROM[idx]. Next edge -> IDLE unconditionally.
//         A request is never accepted on the edge that ends RESP.
//  Timing: strobe sampled at the end of cycle 0 -> m_ready high during cycle LATENCY only.
//   Back-to-back misses: next accept is no earlier than the end of cycle LATENCY+1.
//  Commit: an accepted request always completes. m_strobe dropping, or m_a changing during
//   WAIT/RESP (cache flush on exception/redirect), does not abort or alter it.
//   The cache discards that response; the new address is accepted from IDLE afterwards.
//  m_dout changes only on the edge entering RESP and keeps its value between responses.
//  Reset mid-request: the request is dropped immediately; no m_ready follows after clrn rises.
//  m_busy = (state!=IDLE). cnt is $clog2(16) = 4 bits; LATENCY is checked at elaboration.
// CONFIGURATION
//  IMEM_RANGE_CHECK_EN defined:
//   - On accept, compare m_a upper bits with BASE_ADDR upper bits.
//   - On mismatch: the response timing is unchanged; in RESP m_dout=32'h0 and m_err=1.
//   - Otherwise m_err=0.
//  IMEM_RANGE_CHECK_EN undefined: upper bits are ignored (addresses alias modulo depth);
//   m_err is tied 0 and the comparator is not built.
// STRUCTURE
//  imem_defs.vh (shared include): state encodings IMEM_IDLE/IMEM_WAIT/IMEM_RESP (2 bits),
//   IMEM_LAT_MAX=15, IMEM_CNT_W=4.
//  Sub-module imem_rom:
//   - synchronous 1-port read ROM with address, read enable and 32-bit registered data;
//   - INIT_FILE passed through.
//  The top level holds the FSM, counter, address latch, range check and output registers.
// TESTING (ROM preloaded with word[i]=32'hA000_0000+i; LATENCY=4 unless noted)
//  1 Reset: clrn=0 with strobe=1 -> m_ready=0, m_dout=0, m_busy=0; clrn rises, strobe high
//    at the end of cycle 0 -> m_ready only in cycle 4.
//  2 Single read: m_a=32'h0000_0010, strobe held -> m_ready one cycle at cycle 4,
//    m_dout=32'hA000_0004; dout holds after.
//  3 Flush mid-request: accept 0x10; in cycle 2 m_a=0x80 with strobe held -> cycle 4 returns
//    A000_0004; 0x80 accepted at end of cycle 5; m_ready at cycle 9 with A000_0020.
//  4 Strobe drop: accept 0x8, strobe=0 from cycle 1 -> m_ready still at cycle 4 (A000_0002);
//    no second response.
//  5 LATENCY=1: strobe held, m_a=0x4 then 0x8 -> ready in cycle 1 (A000_0001); next accept at
//    end of cycle 2; ready in cycle 3 (A000_0002).
//  6 With IMEM_RANGE_CHECK_EN, BASE_ADDR=0: m_a=32'h1000_0000 -> cycle 4 m_ready=1, m_err=1,
//    m_dout=0; without the macro -> m_err=0, m_dout=A000_0000.

Source files
------------

// File: rtl/imem_responder_pkg.sv
// Shared definitions for the I-cache miss responder: FSM state encodings and
// latency/counter limits.
package imem_responder_pkg;

  typedef enum logic [1:0] {
    IMEM_IDLE = 2'd0,
    IMEM_WAIT = 2'd1,
    IMEM_RESP = 2'd2
  } imem_state_t;

  localparam int IMEM_LAT_MAX = 15;
  localparam int IMEM_CNT_W   = $clog2(IMEM_LAT_MAX + 1);

endpackage

// File: rtl/imem_responder_rom.sv
// Word ROM with one synchronous read port; the data register doubles as the
// responder's m_dout register, so it only moves when a read is issued.
module imem_rom #(
  parameter int    IDX_W     = 10,
  parameter string INIT_FILE = "imem.hex"
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             re,
  input  logic             kill,
  input  logic [IDX_W-1:0] addr,
  output logic [31:0]      data
);

  localparam int DEPTH = 1 << IDX_W;

  // Image is loaded by the implementation flow (INIT_FILE) or a bench backdoor.
  localparam bit unused_has_image = (INIT_FILE != "");

  logic [31:0] mem [DEPTH];

  // NOTE: only the read register is reset; the array keeps no reset so it can map to block RAM.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      data <= 32'h0;
    end else if (re) begin
      data <= kill ? 32'h0 : mem[addr];
    end
  end

endmodule

// File: rtl/imem_responder.sv
// Memory-side responder for the I-cache miss interface: one word read per
// request, fixed LATENCY, one-cycle m_ready. Optional range check: IMEM_RANGE_CHECK_EN.
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter int                 A_WIDTH   = 32,
  parameter int                 IDX_W     = 10,
  parameter int                 LATENCY   = 4,
  parameter logic [A_WIDTH-1:0] BASE_ADDR = '0,
  parameter string              INIT_FILE = "imem.hex"
) (
  input  logic               clk,
  input  logic               clrn,
  input  logic [A_WIDTH-1:0] m_a,
  input  logic               m_strobe,
  output logic [31:0]        m_dout,
  output logic               m_ready,
  output logic               m_busy,
  output logic               m_err
);

  if (LATENCY < 1 || LATENCY > IMEM_LAT_MAX) begin : g_bad_latency
    $error("imem_responder: LATENCY must be in 1..15");
  end

  imem_state_t           state, next_state;
  logic [IMEM_CNT_W-1:0] cnt;
  logic [IDX_W-1:0]      idx_q;
  logic [IDX_W-1:0]      rd_addr;
  logic                  accept;
  logic                  enter_resp;
  logic                  kill;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state <= IMEM_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // NOTE: every output of this block gets a default first, so no latch can be inferred.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    enter_resp = 1'b0;
    unique case (state)
      IMEM_IDLE: begin
        if (m_strobe) begin
          accept = 1'b1;
          if (LATENCY == 1) begin
            next_state = IMEM_RESP;
            enter_resp = 1'b1;
          end else begin
            next_state = IMEM_WAIT;
          end
        end
      end
      IMEM_WAIT: begin
        if (cnt == IMEM_CNT_W'(1)) begin
          next_state = IMEM_RESP;
          enter_resp = 1'b1;
        end
      end
      IMEM_RESP: next_state = IMEM_IDLE;
      default:   next_state = IMEM_IDLE;
    endcase
  end

  // With LATENCY==1 the RESP entry edge is the accept edge, so read straight from m_a.
  assign rd_addr = (state == IMEM_IDLE) ? m_a[IDX_W+1:2] : idx_q;

`ifdef IMEM_RANGE_CHECK_EN
  logic addr_miss;
  logic err_q;
  logic unused_low;

  assign addr_miss  = (m_a[A_WIDTH-1:IDX_W+2] != BASE_ADDR[A_WIDTH-1:IDX_W+2]);
  assign unused_low = ^m_a[1:0];

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= addr_miss;
    end
  end

  assign kill = (state == IMEM_IDLE) ? addr_miss : err_q;
`else
  logic unused_bits;

  // Upper address bits alias modulo the ROM depth in this build.
  assign unused_bits = ^{m_a[A_WIDTH-1:IDX_W+2], m_a[1:0], BASE_ADDR};
  assign kill        = 1'b0;
`endif

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      cnt     <= '0;
      idx_q   <= '0;
      m_ready <= 1'b0;
      m_busy  <= 1'b0;
      m_err   <= 1'b0;
    end else begin
      if (accept) begin
        cnt   <= IMEM_CNT_W'(LATENCY - 1);
        idx_q <= m_a[IDX_W+1:2];
      end else if (state == IMEM_WAIT) begin
        cnt <= cnt - IMEM_CNT_W'(1);
      end
      m_ready <= enter_resp;
      m_busy  <= (next_state != IMEM_IDLE);
      m_err   <= enter_resp & kill;
    end
  end

  imem_rom #(
    .IDX_W     (IDX_W),
    .INIT_FILE (INIT_FILE)
  ) u_rom (
    .clk  (clk),
    .clrn (clrn),
    .re   (enter_resp),
    .kill (kill),
    .addr (rd_addr),
    .data (m_dout)
  );

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: LATENCY=4 and LATENCY=1 instances, ROM word[i]=A000_0000+i,
// per-instance response scoreboards keyed by the cycle the response is due.
module tb_imem_responder;

  typedef struct {
    logic [31:0] dout;
    logic        err;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] dout;
    logic        err;
  } vec_t;

`ifdef IMEM_RANGE_CHECK_EN
  localparam bit RANGE_CHK = 1'b1;
`else
  localparam bit RANGE_CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        clrn = 1'b0;
  logic [31:0] a4 = '0, a1 = '0;
  logic        s4 = 1'b0, s1 = 1'b0;
  logic [31:0] dout4, dout1;
  logic        ready4, ready1, busy4, busy1, err4, err1;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t q4[$];
  exp_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  imem_responder #(
    .A_WIDTH(32), .IDX_W(10), .LATENCY(4), .BASE_ADDR(32'h0), .INIT_FILE("")
  ) dut (
    .clk(clk), .clrn(clrn), .m_a(a4), .m_strobe(s4),
    .m_dout(dout4), .m_ready(ready4), .m_busy(busy4), .m_err(err4)
  );

  imem_responder #(
    .A_WIDTH(32), .IDX_W(10), .LATENCY(1), .BASE_ADDR(32'h0), .INIT_FILE("")
  ) dut1 (
    .clk(clk), .clrn(clrn), .m_a(a1), .m_strobe(s1),
    .m_dout(dout1), .m_ready(ready1), .m_busy(busy1), .m_err(err1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push4(input logic [31:0] d, input logic e, input int c);
    exp_t x;
    x.dout = d; x.err = e; x.cyc = c;
    q4.push_back(x);
  endtask

  task automatic push1(input logic [31:0] d, input logic e, input int c);
    exp_t x;
    x.dout = d; x.err = e; x.cyc = c;
    q1.push_back(x);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Scoreboards: m_ready must be high exactly in the cycle a response is due.
  always @(negedge clk) begin : mon4
    logic due;
    if (clrn) begin
      due = (q4.size() > 0) && (q4[0].cyc == cyc);
      check("ready_l4", {31'b0, ready4}, {31'b0, due});
      if (due) begin
        if (ready4) begin
          check("dout_l4", dout4, q4[0].dout);
          check("err_l4", {31'b0, err4}, {31'b0, q4[0].err});
        end
        void'(q4.pop_front());
      end
    end
  end

  always @(negedge clk) begin : mon1
    logic due;
    if (clrn) begin
      due = (q1.size() > 0) && (q1[0].cyc == cyc);
      check("ready_l1", {31'b0, ready1}, {31'b0, due});
      if (due) begin
        if (ready1) begin
          check("dout_l1", dout1, q1[0].dout);
          check("err_l1", {31'b0, err1}, {31'b0, q1[0].err});
        end
        void'(q1.pop_front());
      end
    end
  end

  vec_t vecs[7];

  initial begin
    vecs[0] = '{addr: 32'h0000_0010, dout: 32'hA000_0004, err: 1'b0};
    vecs[1] = '{addr: 32'h0000_0000, dout: 32'hA000_0000, err: 1'b0};
    vecs[2] = '{addr: 32'h0000_0FFC, dout: 32'hA000_03FF, err: 1'b0};
    vecs[3] = '{addr: 32'h0000_0013, dout: 32'hA000_0004, err: 1'b0};
    vecs[4] = '{addr: 32'h0000_02A8, dout: 32'hA000_00AA, err: 1'b0};
    vecs[5] = '{addr: 32'h0000_1000, dout: RANGE_CHK ? 32'h0 : 32'hA000_0000, err: RANGE_CHK};
    vecs[6] = '{addr: 32'h1000_0000, dout: RANGE_CHK ? 32'h0 : 32'hA000_0000, err: RANGE_CHK};

    for (int i = 0; i < 1024; i++) begin
      dut.u_rom.mem[i]  = 32'hA000_0000 + 32'(i);
      dut1.u_rom.mem[i] = 32'hA000_0000 + 32'(i);
    end

    // Reset with strobe held, then accept on the first edge after release.
    clrn = 1'b0; s4 = 1'b1; a4 = 32'h0;
    cycles(2);
    check("rst_ready", {31'b0, ready4}, 32'h0);
    check("rst_dout", dout4, 32'h0);
    check("rst_busy", {31'b0, busy4}, 32'h0);
    check("rst_err", {31'b0, err4}, 32'h0);
    check("rst_busy_l1", {31'b0, busy1}, 32'h0);
    clrn = 1'b1;
    push4(32'hA000_0000, 1'b0, cyc + 4);
    cycles(1);
    check("busy_wait", {31'b0, busy4}, 32'h1);
    cycles(3);
    check("busy_resp", {31'b0, busy4}, 32'h1);
    s4 = 1'b0;
    cycles(1);
    check("busy_idle", {31'b0, busy4}, 32'h0);

    // Single reads from the vector table; dout must hold after each response.
    for (int i = 0; i < 7; i++) begin
      a4 = vecs[i].addr; s4 = 1'b1;
      push4(vecs[i].dout, vecs[i].err, cyc + 4);
      cycles(4);
      s4 = 1'b0;
      cycles(2);
      check($sformatf("hold_%0d", i), dout4, vecs[i].dout);
      check($sformatf("idle_busy_%0d", i), {31'b0, busy4}, 32'h0);
    end

    // Flush mid-request: address changes in cycle 2 while strobe stays high.
    a4 = 32'h10; s4 = 1'b1;
    push4(32'hA000_0004, 1'b0, cyc + 4);
    push4(32'hA000_0020, 1'b0, cyc + 9);
    cycles(2);
    a4 = 32'h80;
    cycles(7);
    s4 = 1'b0;
    cycles(2);

    // Strobe drop after accept: response still arrives, only once.
    a4 = 32'h8; s4 = 1'b1;
    push4(32'hA000_0002, 1'b0, cyc + 4);
    cycles(1);
    s4 = 1'b0; a4 = 32'h40;
    cycles(10);
    check("drop_hold", dout4, 32'hA000_0002);

    // Reset mid-request: the in-flight read is dropped.
    a4 = 32'h20; s4 = 1'b1;
    cycles(1);
    s4 = 1'b0;
    cycles(1);
    clrn = 1'b0;
    #1;
    check("midrst_busy", {31'b0, busy4}, 32'h0);
    check("midrst_dout", dout4, 32'h0);
    cycles(1);
    clrn = 1'b1;
    cycles(8);
    check("midrst_dout_after", dout4, 32'h0);

    // LATENCY=1: strobe held across two requests.
    a1 = 32'h4; s1 = 1'b1;
    push1(32'hA000_0001, 1'b0, cyc + 1);
    cycles(1);
    a1 = 32'h8;
    push1(32'hA000_0002, 1'b0, cyc + 2);
    cycles(2);
    s1 = 1'b0;
    cycles(3);
    check("l1_hold", dout1, 32'hA000_0002);

    check("q4_drained", 32'(q4.size()), 32'h0);
    check("q1_drained", 32'(q1.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
